// File: rtl/sync_edge_timestamper.sv
// LSYNC/RSYNC front end: 2-FF synchronisers, glitch filters, edge timestamps
// against a free-running 32-bit timer, scan direction tracking and sync-loss timeout.
module sync_edge_timestamper #(
   parameter int unsigned FILTER_LEN  = 4,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lsync_in,
   input  logic        rsync_in,
   output logic [31:0] time_now,
   output logic [31:0] lsync_rise_time,
   output logic [31:0] lsync_fall_time,
   output logic [31:0] rsync_rise_time,
   output logic [31:0] rsync_fall_time,
   output logic        scan_dir,
   output logic        sync_pulse,
   output logic        sync_timeout,
   output logic [1:0]  dir_state
);

   localparam int CH_L = 0;
   localparam int CH_R = 1;

   localparam logic [3:0]  FILT_LAST    = 4'(FILTER_LEN - 1);
   // Captured on the edge where time_now still holds T+1+FILTER_LEN, so the
   // offset is one less than the distance to the value visible afterwards.
   localparam logic [31:0] STAMP_OFFSET = 32'(FILTER_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LTR  = 2'd1,
      RTL  = 2'd2
   } dir_state_t;

   logic [1:0]  raw;
   logic [1:0]  sync_a;
   logic [1:0]  sync_b;
   logic [1:0]  level;
   logic [3:0]  filt_cnt [2];
   logic [1:0]  differ;
   logic [1:0]  accept;
   logic [1:0]  rise_evt;
   logic [1:0]  fall_evt;
   logic [31:0] stamp;
   logic [31:0] to_cnt;
   logic        pulse_arm;
   dir_state_t  state_q;
   dir_state_t  state_d;
   logic        scan_dir_d;

   assign raw = {rsync_in, lsync_in};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   always_comb begin
      differ   = sync_b ^ level;
      accept   = '0;
      for (int i = 0; i < 2; i++) begin
         accept[i] = differ[i] && (filt_cnt[i] == FILT_LAST);
      end
      rise_evt = accept & ~level;
      fall_evt = accept & level;
   end

   // A sample matching the filtered level restarts the run of differing samples.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level       <= '0;
         filt_cnt[0] <= '0;
         filt_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!differ[i]) begin
               filt_cnt[i] <= '0;
            end else if (accept[i]) begin
               filt_cnt[i] <= '0;
               level[i]    <= ~level[i];
            end else begin
               filt_cnt[i] <= filt_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign stamp = time_now - STAMP_OFFSET;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         time_now        <= '0;
         lsync_rise_time <= '0;
         lsync_fall_time <= '0;
         rsync_rise_time <= '0;
         rsync_fall_time <= '0;
      end else begin
         time_now <= time_now + 32'd1;
         if (rise_evt[CH_L]) lsync_rise_time <= stamp;
         if (fall_evt[CH_L]) lsync_fall_time <= stamp;
         if (rise_evt[CH_R]) rsync_rise_time <= stamp;
         if (fall_evt[CH_R]) rsync_fall_time <= stamp;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else if (|fall_evt) begin
         to_cnt <= '0;
      end else if (to_cnt != TIMEOUT_CYC) begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   assign sync_timeout = (to_cnt == TIMEOUT_CYC);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         scan_dir <= 1'b0;
      end else begin
         state_q  <= state_d;
         scan_dir <= scan_dir_d;
      end
   end

   // RSYNC wins when both channels fall together; direction survives a timeout.
   always_comb begin
      state_d    = state_q;
      scan_dir_d = scan_dir;
      if (fall_evt[CH_R]) begin
         state_d    = LTR;
         scan_dir_d = 1'b0;
      end else if (fall_evt[CH_L]) begin
         state_d    = RTL;
         scan_dir_d = 1'b1;
      end else if (sync_timeout) begin
         state_d    = IDLE;
      end
   end

   assign dir_state = state_q;

   // The extra stage lets the pulse land once timestamps and scan_dir are settled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pulse_arm  <= 1'b0;
         sync_pulse <= 1'b0;
      end else begin
         pulse_arm  <= |fall_evt;
         sync_pulse <= pulse_arm;
      end
   end

endmodule

// File: tb/tb_sync_edge_timestamper.sv
// Directed bench for sync_edge_timestamper with FILTER_LEN=4 and TIMEOUT_CYC=20.
module tb_sync_edge_timestamper;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        lsync_in;
   logic        rsync_in;
   logic [31:0] time_now;
   logic [31:0] lsync_rise_time;
   logic [31:0] lsync_fall_time;
   logic [31:0] rsync_rise_time;
   logic [31:0] rsync_fall_time;
   logic        scan_dir;
   logic        sync_pulse;
   logic        sync_timeout;
   logic [1:0]  dir_state;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] now;
   int          pulse_cnt = 0;
   logic [31:0] pulse_at = '0;
   logic [31:0] wrap_timer;

   sync_edge_timestamper #(
      .FILTER_LEN  (4),
      .TIMEOUT_CYC (32'd20)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .lsync_in        (lsync_in),
      .rsync_in        (rsync_in),
      .time_now        (time_now),
      .lsync_rise_time (lsync_rise_time),
      .lsync_fall_time (lsync_fall_time),
      .rsync_rise_time (rsync_rise_time),
      .rsync_fall_time (rsync_fall_time),
      .scan_dir        (scan_dir),
      .sync_pulse      (sync_pulse),
      .sync_timeout    (sync_timeout),
      .dir_state       (dir_state)
   );

   // clock / reset, reference timer and pulse recorder
   always #5 clk = ~clk;

   always @(posedge clk) now <= reset_n ? now + 32'd1 : 32'd0;

   always @(negedge clk) begin
      if (sync_pulse === 1'b1) begin
         pulse_cnt = pulse_cnt + 1;
         pulse_at  = now;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input logic [31:0] t);
      int budget = 3000;
      while (now != t && budget > 0) begin
         step();
         budget--;
      end
      vectors++;
      if (now != t) begin
         miscompares++;
         $display("FAIL wait_until: now=%0d required=%0d", now, t);
      end
   endtask

   task automatic do_reset(input logic l, input logic r);
      reset_n  = 1'b0;
      lsync_in = l;
      rsync_in = r;
      repeat (3) step();
      reset_n  = 1'b1;
      pulse_cnt = 0;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      lsync_in = 1'b1;
      rsync_in = 1'b1;
      repeat (3) step();
      vectors++;
      if ({time_now, lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time,
           scan_dir, sync_pulse, sync_timeout, dir_state} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got t=%h lr=%h lf=%h rr=%h rf=%h dir=%b p=%b to=%b st=%h required all 0",
                  time_now, lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time,
                  scan_dir, sync_pulse, sync_timeout, dir_state);
      end
   endtask

   task automatic test_rtl_scan();
      do_reset(1'b0, 1'b0);
      wait_until(32'd100);
      lsync_in = 1'b1;
      wait_until(32'd105);
      vectors++;
      if (lsync_rise_time !== 32'd0) begin
         miscompares++;
         $display("FAIL rise_latency: got %0d required 0", lsync_rise_time);
      end
      step();
      vectors++;
      if (lsync_rise_time !== 32'd100) begin
         miscompares++;
         $display("FAIL lsync_rise: got %0d required 100", lsync_rise_time);
      end
      vectors++;
      if (time_now !== 32'd106) begin
         miscompares++;
         $display("FAIL timer: got %0d required 106", time_now);
      end
      wait_until(32'd150);
      lsync_in  = 1'b0;
      pulse_cnt = 0;
      wait_until(32'd155);
      vectors++;
      if (sync_timeout !== 1'b1 || lsync_fall_time !== 32'd0) begin
         miscompares++;
         $display("FAIL pre_fall: got to=%b lf=%0d required to=1 lf=0", sync_timeout, lsync_fall_time);
      end
      step();
      vectors++;
      if (lsync_fall_time !== 32'd150 || scan_dir !== 1'b1 || dir_state !== 2'd2 || sync_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL lsync_fall: got lf=%0d dir=%b st=%0d to=%b required lf=150 dir=1 st=2 to=0",
                  lsync_fall_time, scan_dir, dir_state, sync_timeout);
      end
      wait_until(32'd160);
      vectors++;
      if (pulse_cnt != 1 || pulse_at !== 32'd157) begin
         miscompares++;
         $display("FAIL rtl_pulse: got count=%0d at=%0d required count=1 at=157", pulse_cnt, pulse_at);
      end
   endtask

   task automatic test_short_pulse();
      wait_until(32'd162);
      pulse_cnt = 0;
      rsync_in  = 1'b1;
      wait_until(32'd165);
      rsync_in  = 1'b0;
      wait_until(32'd175);
      vectors++;
      if (rsync_rise_time !== 32'd0 || rsync_fall_time !== 32'd0 || pulse_cnt != 0) begin
         miscompares++;
         $display("FAIL glitch_ignored: got rr=%0d rf=%0d pulses=%0d required 0 0 0",
                  rsync_rise_time, rsync_fall_time, pulse_cnt);
      end
      vectors++;
      if (sync_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: got %b required 0", sync_timeout);
      end
      step();
      vectors++;
      if (sync_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_after_fall: got %b required 1", sync_timeout);
      end
      step();
      vectors++;
      if (dir_state !== 2'd0 || scan_dir !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_on_timeout: got st=%0d dir=%b required st=0 dir=1", dir_state, scan_dir);
      end
   endtask

   task automatic test_ltr_scan();
      do_reset(1'b0, 1'b0);
      wait_until(32'd200);
      lsync_in = 1'b1;
      wait_until(32'd210);
      lsync_in = 1'b0;
      wait_until(32'd216);
      vectors++;
      if (lsync_rise_time !== 32'd200 || lsync_fall_time !== 32'd210 || scan_dir !== 1'b1) begin
         miscompares++;
         $display("FAIL ltr_lsync: got lr=%0d lf=%0d dir=%b required 200 210 1",
                  lsync_rise_time, lsync_fall_time, scan_dir);
      end
      wait_until(32'd900);
      rsync_in = 1'b1;
      wait_until(32'd910);
      rsync_in  = 1'b0;
      pulse_cnt = 0;
      wait_until(32'd915);
      vectors++;
      if (scan_dir !== 1'b1) begin
         miscompares++;
         $display("FAIL ltr_dir_latency: got %b required 1", scan_dir);
      end
      step();
      vectors++;
      if (rsync_rise_time !== 32'd900 || rsync_fall_time !== 32'd910 || scan_dir !== 1'b0 || dir_state !== 2'd1) begin
         miscompares++;
         $display("FAIL ltr_rsync: got rr=%0d rf=%0d dir=%b st=%0d required 900 910 0 1",
                  rsync_rise_time, rsync_fall_time, scan_dir, dir_state);
      end
      vectors++;
      if ((lsync_rise_time - rsync_rise_time) < 32'h8000_0000) begin
         miscompares++;
         $display("FAIL ltr_predictor: got diff=%h required >= 80000000", lsync_rise_time - rsync_rise_time);
      end
      wait_until(32'd925);
      vectors++;
      if (pulse_cnt != 1 || pulse_at !== 32'd917) begin
         miscompares++;
         $display("FAIL ltr_pulse: got count=%0d at=%0d required count=1 at=917", pulse_cnt, pulse_at);
      end
   endtask

   task automatic test_simultaneous();
      do_reset(1'b0, 1'b0);
      wait_until(32'd480);
      lsync_in = 1'b1;
      rsync_in = 1'b1;
      wait_until(32'd500);
      lsync_in  = 1'b0;
      rsync_in  = 1'b0;
      pulse_cnt = 0;
      wait_until(32'd506);
      vectors++;
      if (lsync_fall_time !== 32'd500 || rsync_fall_time !== 32'd500 ||
          lsync_rise_time !== 32'd480 || rsync_rise_time !== 32'd480) begin
         miscompares++;
         $display("FAIL simul_stamps: got lr=%0d lf=%0d rr=%0d rf=%0d required 480 500 480 500",
                  lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time);
      end
      vectors++;
      if (scan_dir !== 1'b0 || dir_state !== 2'd1) begin
         miscompares++;
         $display("FAIL simul_priority: got dir=%b st=%0d required dir=0 st=1", scan_dir, dir_state);
      end
      wait_until(32'd515);
      vectors++;
      if (pulse_cnt != 1 || pulse_at !== 32'd507) begin
         miscompares++;
         $display("FAIL simul_pulse: got count=%0d at=%0d required count=1 at=507", pulse_cnt, pulse_at);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0, 1'b0);
      wait_until(32'd300);
      lsync_in = 1'b1;
      wait_until(32'd320);
      lsync_in  = 1'b0;
      rsync_in  = 1'b1;
      pulse_cnt = 0;
      wait_until(32'd326);
      vectors++;
      if (lsync_fall_time !== 32'd320 || rsync_rise_time !== 32'd320 || scan_dir !== 1'b1) begin
         miscompares++;
         $display("FAIL mixed_edges: got lf=%0d rr=%0d dir=%b required 320 320 1",
                  lsync_fall_time, rsync_rise_time, scan_dir);
      end
      wait_until(32'd335);
      vectors++;
      if (pulse_cnt != 1 || pulse_at !== 32'd327) begin
         miscompares++;
         $display("FAIL mixed_pulse: got count=%0d at=%0d required count=1 at=327", pulse_cnt, pulse_at);
      end
   endtask

   task automatic test_timer_wrap();
      do_reset(1'b0, 1'b0);
      wrap_timer = 32'hFFFF_FFFE;
      force dut.time_now = wrap_timer;
      step();
      wrap_timer = 32'hFFFF_FFFF;
      force dut.time_now = wrap_timer;
      lsync_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         wrap_timer = wrap_timer + 32'd1;
         force dut.time_now = wrap_timer;
      end
      vectors++;
      if (lsync_rise_time !== 32'd0) begin
         miscompares++;
         $display("FAIL wrap_latency: got %h required 0", lsync_rise_time);
      end
      step();
      wrap_timer = wrap_timer + 32'd1;
      force dut.time_now = wrap_timer;
      vectors++;
      if (lsync_rise_time !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("FAIL wrap_rise: got %h required ffffffff", lsync_rise_time);
      end
      release dut.time_now;
   endtask

   task automatic test_reset_high_input();
      do_reset(1'b0, 1'b1);
      wait_until(32'd10);
      rsync_in  = 1'b0;
      pulse_cnt = 0;
      wait_until(32'd16);
      vectors++;
      if (rsync_fall_time !== 32'd10 || rsync_rise_time !== 32'd0 || scan_dir !== 1'b0 || dir_state !== 2'd1) begin
         miscompares++;
         $display("FAIL high_at_release: got rr=%0d rf=%0d dir=%b st=%0d required 0 10 0 1",
                  rsync_rise_time, rsync_fall_time, scan_dir, dir_state);
      end
      wait_until(32'd20);
      vectors++;
      if (pulse_cnt != 1 || pulse_at !== 32'd17) begin
         miscompares++;
         $display("FAIL high_release_pulse: got count=%0d at=%0d required count=1 at=17", pulse_cnt, pulse_at);
      end
   endtask

   task automatic test_timeout();
      do_reset(1'b0, 1'b0);
      wait_until(32'd19);
      vectors++;
      if (sync_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_19: got %b required 0", sync_timeout);
      end
      step();
      vectors++;
      if (sync_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_20: got %b required 1", sync_timeout);
      end
      wait_until(32'd30);
      vectors++;
      if (sync_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_saturate: got %b required 1", sync_timeout);
      end
      rsync_in = 1'b1;
      wait_until(32'd40);
      rsync_in = 1'b0;
      wait_until(32'd45);
      vectors++;
      if (sync_timeout !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_rise_no_clear: got %b required 1", sync_timeout);
      end
      step();
      vectors++;
      if (sync_timeout !== 1'b0 || rsync_fall_time !== 32'd40) begin
         miscompares++;
         $display("FAIL timeout_clear: got to=%b rf=%0d required to=0 rf=40", sync_timeout, rsync_fall_time);
      end
      wait_until(32'd50);
      lsync_in = 1'b1;
      wait_until(32'd53);
      reset_n  = 1'b0;
      lsync_in = 1'b0;
      step();
      vectors++;
      if ({time_now, lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time,
           scan_dir, sync_pulse, sync_timeout, dir_state} !== '0) begin
         miscompares++;
         $display("FAIL midpulse_reset: got t=%h lr=%h lf=%h rr=%h rf=%h dir=%b p=%b to=%b st=%h required all 0",
                  time_now, lsync_rise_time, lsync_fall_time, rsync_rise_time, rsync_fall_time,
                  scan_dir, sync_pulse, sync_timeout, dir_state);
      end
      reset_n   = 1'b1;
      pulse_cnt = 0;
      repeat (12) step();
      vectors++;
      if (lsync_rise_time !== 32'd0 || lsync_fall_time !== 32'd0 || pulse_cnt != 0) begin
         miscompares++;
         $display("FAIL midpulse_no_edge: got lr=%0d lf=%0d pulses=%0d required 0 0 0",
                  lsync_rise_time, lsync_fall_time, pulse_cnt);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      lsync_in = 1'b0;
      rsync_in = 1'b0;
      test_reset();
      test_rtl_scan();
      test_short_pulse();
      test_ltr_scan();
      test_simultaneous();
      test_back_to_back();
      test_timer_wrap();
      test_reset_high_input();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sync_edge_timestamper.md
Name: sync_edge_timestamper

Overview:
Front end that feeds the split-sync predictor with the timing data it consumes.
- Synchronises and glitch-filters the raw LSYNC/RSYNC photodetector inputs.
- Timestamps each filtered rise and fall against a free-running 32-bit timer.
- Reports scan direction and emits a one-cycle sync_pulse on every accepted SYNC fall.
- Flags missing sync with a timeout.

Parameters:
FILTER_LEN, 4, consecutive identical synchronised samples required to accept a level change (1..15)
TIMEOUT_CYC, 32'd1000000, cycles without an accepted fall before sync_timeout asserts

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
lsync_in  input  1  raw asynchronous LSYNC detector level
rsync_in  input  1  raw asynchronous RSYNC detector level
time_now  output  32  free-running timer, +1 per clk, wraps mod 2^32
lsync_rise_time  output  32  timestamp of last accepted LSYNC rise
lsync_fall_time  output  32  timestamp of last accepted LSYNC fall
rsync_rise_time  output  32  timestamp of last accepted RSYNC rise
rsync_fall_time  output  32  timestamp of last accepted RSYNC fall
scan_dir  output  1  0 = LTR completed (last SYNC was RSYNC fall), 1 = RTL completed (LSYNC fall)
sync_pulse  output  1  one-cycle strobe; all timestamps and scan_dir stable when high
sync_timeout  output  1  high while no fall has been accepted for TIMEOUT_CYC cycles

Behaviour:
- Reset (reset_n low at posedge):
  - time_now, all timestamps, scan_dir, sync_pulse, sync_timeout and timeout counter <= 0.
  - Synchroniser FFs, filter counters and filtered levels <= 0.
  - FSM <= IDLE.
  - Reset mid-pulse discards partial filter counts; no edge is reported for it.
- Input path, per channel:
  - 2-FF synchroniser, then filter.
  - Filter counts consecutive synchronised samples differing from the filtered level.
  - Count reaching FILTER_LEN flips the filtered level and raises an edge event.
  - Any sample equal to the filtered level clears the count.
  - Pulses or gaps shorter than FILTER_LEN cycles are ignored entirely.
- Timestamp rule:
  - Raw level first sampled at the clk edge where time_now = T, and held >= FILTER_LEN cycles, gives a recorded timestamp of exactly T.
  - Implementation registers time_now - (2 + FILTER_LEN) mod 2^32.
  - Timestamp register updates at time_now = T + 2 + FILTER_LEN; detection latency is fixed.
  - Subtraction wraps modulo 2^32; a timestamp near 0 after timer wrap is legal.
- sync_pulse:
  - High for exactly one cycle, one cycle after the fall timestamp register update (T + 3 + FILTER_LEN).
  - Rise events update timestamps only; no pulse.
- Direction FSM, states IDLE, LTR, RTL:
  - Accepted RSYNC fall -> LTR, scan_dir <= 0.
  - Accepted LSYNC fall -> RTL, scan_dir <= 1.
  - scan_dir updates in the same cycle as the fall timestamp.
  - Same-channel consecutive falls are legal (repeat state, re-pulse).
- Simultaneous falls (same cycle):
  - Both fall timestamps update.
  - A single sync_pulse is issued.
  - RSYNC has priority: scan_dir <= 0, state LTR.
- Rise and fall of different channels in the same cycle: both timestamps update independently.
- Timeout:
  - Counter clears on every accepted fall and saturates at TIMEOUT_CYC.
  - sync_timeout = (count == TIMEOUT_CYC).
  - sync_timeout deasserts in the cycle the next fall is accepted.
  - FSM returns to IDLE on timeout; scan_dir holds its value.
- Inputs high at reset release: accepted as a rise after the filter latency (timestamp 0 if high from the first sample).

Test Plan:
1. Reset release, lsync_in 0->1 sampled at time_now=100, held 50 cycles -> lsync_rise_time=100 at time_now=106, lsync_fall_time=150 at 156, sync_pulse high only at 157, scan_dir=1.
2. rsync_in high for 3 cycles (shorter than FILTER_LEN=4) -> no timestamp change, no sync_pulse.
3. LTR scan: lsync high 200..210, rsync high 900..910 -> rsync_fall_time=910, scan_dir=0, one pulse at 917; predictor-style check (lsync_rise - rsync_rise) >= 2^31.
4. Both channels fall in the same sampled cycle T=500 -> both fall times = 500, exactly one pulse at 507, scan_dir=0.
5. Timer wrap: force time_now to 32'hFFFF_FFFE, rise sampled at 32'hFFFF_FFFF -> lsync_rise_time=32'hFFFF_FFFF, recorded after wrap.
6. TIMEOUT_CYC=20, no falls -> sync_timeout high 20 cycles after reset. Then an RSYNC fall -> sync_timeout low in the fall-accept cycle. Assert reset_n low mid-pulse -> all outputs 0 next cycle, no edge reported.
